oled_spi_arbiter: RTL and testbench

OLED_SPI_ARBITER -- requirements
Module: oled_spi_arbiter

---
 rtl/oled_spi_arbiter_if.sv | 29 ++
 rtl/oled_spi_arbiter.sv | 102 ++++++++++
 tb/tb_oled_spi_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_spi_arbiter_if.sv
// rtl/oled_spi_arbiter_if.sv - requester/SPI-transmitter bundle for the OLED SPI arbiter
interface oled_spi_arbiter_if #(
    parameter int N_REQ        = 3,
    parameter int PACKET_WIDTH = 8
);
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ*PACKET_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]              req_dc;
    logic [N_REQ-1:0]              req_last;
    logic [N_REQ-1:0]              req_ready;
    logic                          spi_valid;
    logic [PACKET_WIDTH-1:0]       spi_data;
    logic                          spi_dc;
    logic                          spi_ready;
    logic                          spi_idle;
    logic                          cs_n;
    logic [N_REQ-1:0]              grant;
    logic                          busy;

    modport slave (
        input  req_valid, req_data, req_dc, req_last, spi_ready, spi_idle,
        output req_ready, spi_valid, spi_data, spi_dc, cs_n, grant, busy
    );

    modport master (
        output req_valid, req_data, req_dc, req_last, spi_ready, spi_idle,
        input  req_ready, spi_valid, spi_data, spi_dc, cs_n, grant, busy
    );
endinterface

// File: rtl/oled_spi_arbiter.sv
// rtl/oled_spi_arbiter.sv - round-robin packet arbiter sharing one OLED SPI byte transmitter
module oled_spi_arbiter #(
    parameter int N_REQ        = 3,
    parameter int PACKET_WIDTH = 8,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    oled_spi_arbiter_if.slave   bus
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [IW-1:0]           owner_q, owner_d;
    logic [7:0]              gap_q, gap_d;
    logic [IW-1:0]           winner;
    logic [IW-1:0]           idx;
    logic                    found;
    logic                    in_xfer, owned, own_valid, xfer_fire;
    logic [PACKET_WIDTH-1:0] own_data;
    logic [N_REQ-1:0]        own_onehot;

    // owner_q doubles as last_owner: it is only rewritten when a new grant is registered
    always_comb begin
        winner = owner_q;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(owner_q) + k) % N_REQ);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign in_xfer    = (state_q == S_XFER);
    assign owned      = in_xfer || (state_q == S_DRAIN);
    assign own_valid  = bus.req_valid[owner_q];
    assign own_data   = bus.req_data[int'(owner_q)*PACKET_WIDTH +: PACKET_WIDTH];
    assign own_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign xfer_fire  = in_xfer && own_valid && bus.spi_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_XFER;
                    owner_d = winner;
                end
            end
            S_XFER: begin
                if (xfer_fire && bus.req_last[owner_q]) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.spi_idle) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= IW'(N_REQ - 1);
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gap_q   <= gap_d;
        end
    end

    // All outputs decode from registered state so reset clears them without a clock
    assign bus.spi_valid = in_xfer && own_valid;
    assign bus.spi_data  = (in_xfer && own_valid) ? own_data : '0;
    assign bus.spi_dc    = in_xfer && own_valid && bus.req_dc[owner_q];
    assign bus.req_ready = (in_xfer && bus.spi_ready) ? own_onehot : '0;
    assign bus.grant     = owned ? own_onehot : '0;
    assign bus.cs_n      = !owned;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_oled_spi_arbiter.sv
// tb/tb_oled_spi_arbiter.sv - randomized model-checked bench for oled_spi_arbiter
module tb_oled_spi_arbiter;
    localparam int N   = 3;
    localparam int PW  = 8;
    localparam int GAP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    oled_spi_arbiter_if #(.N_REQ(N), .PACKET_WIDTH(PW)) bus ();
    oled_spi_arbiter_if #(.N_REQ(N), .PACKET_WIDTH(PW)) bus0 ();

    oled_spi_arbiter #(.N_REQ(N), .PACKET_WIDTH(PW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    oled_spi_arbiter #(.N_REQ(N), .PACKET_WIDTH(PW), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );

    typedef struct packed {
        logic [PW-1:0] d;
        logic          dc;
        logic          last;
    } beat_t;

    beat_t src_q [N][$];
    int    gen_bytes, sent_bytes;
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    hold_valid;
    int    ready_pct, idle_pct;

    // Packet-level reference: who owns the link, whether the last byte went, gap cycles left
    bit    m_owned, m_drain;
    int    m_owner, m_last, m_gap;
    int    p0;
    int    grant_log[$];
    bit    prev_any, run_check_en, seen_low;
    int    cs_run;
    int    fair_exp [6] = '{0, 1, 2, 0, 1, 2};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    function automatic bit pending();
        bit p = m_owned || (m_gap > 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic add_packet(input int r, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d    = PW'($urandom);
            b.dc   = 1'($urandom);
            b.last = (k == len - 1);
            src_q[r].push_back(b);
        end
        gen_bytes += len;
    endtask

    task automatic model_reset();
        m_owned  = 1'b0;
        m_drain  = 1'b0;
        m_gap    = 0;
        m_last   = N - 1;
        p0       = 0;
        prev_any = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit ne = (src_q[i].size() != 0);
            bus.req_valid[i] = ne && (hold_valid || ($urandom_range(99) < 70));
            if (ne) begin
                bus.req_data[i*PW +: PW] = src_q[i][0].d;
                bus.req_dc[i]            = src_q[i][0].dc;
                bus.req_last[i]          = src_q[i][0].last;
            end else begin
                bus.req_data[i*PW +: PW] = PW'($urandom);
                bus.req_dc[i]            = 1'($urandom);
                bus.req_last[i]          = 1'($urandom);
            end
        end
        bus.spi_ready = ($urandom_range(99) < ready_pct);
        bus.spi_idle  = ($urandom_range(99) < idle_pct);
    endtask

    task automatic model_step();
        logic [N-1:0]  e_grant, e_ready;
        logic          e_valid, e_dc;
        logic [PW-1:0] e_data;
        beat_t         b;
        e_valid = m_owned && !m_drain && bus.req_valid[m_owner];
        e_grant = m_owned ? (N'(1) << m_owner) : '0;
        e_ready = (m_owned && !m_drain && bus.spi_ready) ? e_grant : '0;
        e_data  = e_valid ? src_q[m_owner][0].d : '0;
        e_dc    = e_valid ? src_q[m_owner][0].dc : 1'b0;
        chk("cs_n",      32'(bus.cs_n),      32'(!m_owned));
        chk("busy",      32'(bus.busy),      32'(m_owned || (m_gap > 0)));
        chk("grant",     32'(bus.grant),     32'(e_grant));
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("spi_valid", 32'(bus.spi_valid), 32'(e_valid));
        chk("spi_data",  32'(bus.spi_data),  32'(e_data));
        chk("spi_dc",    32'(bus.spi_dc),    32'(e_dc));

        if ((bus.grant != '0) && !prev_any) grant_log.push_back(onehot_idx(bus.grant));
        prev_any = (bus.grant != '0);
        if (bus.cs_n) begin
            cs_run++;
        end else begin
            if (cs_run > 0 && run_check_en && seen_low) chk("cs_high_run", 32'(cs_run), 32'(GAP + 1));
            cs_run   = 0;
            seen_low = 1'b1;
        end

        chk("g0_cs_n",  32'(bus0.cs_n),  32'(p0 == 0));
        chk("g0_grant", 32'(bus0.grant), (p0 == 0) ? 32'd0 : 32'd1);
        p0 = (p0 + 1) % 3;

        if (!m_owned && m_gap == 0) begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (!m_owned && bus.req_valid[c]) begin
                    m_owned = 1'b1;
                    m_owner = c;
                    m_last  = c;
                end
            end
        end else if (m_owned && !m_drain) begin
            if (e_valid && bus.spi_ready) begin
                b = src_q[m_owner].pop_front();
                sent_bytes++;
                if (b.last) m_drain = 1'b1;
            end
        end else if (m_drain) begin
            if (bus.spi_idle) begin
                m_owned = 1'b0;
                m_drain = 1'b0;
                m_gap   = GAP;
            end
        end else begin
            m_gap--;
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input string tag);
        int guard = 0;
        while (pending() && guard < 20000) begin
            cycle();
            guard++;
        end
        chk(tag, 32'(pending()), 32'd0);
    endtask

    initial begin
        bus.req_valid = '0; bus.req_data = '0; bus.req_dc = '0; bus.req_last = '0;
        bus.spi_ready = 1'b0; bus.spi_idle = 1'b0;
        bus0.req_valid = 3'b001; bus0.req_data = 24'h0000_5A; bus0.req_dc = 3'b001;
        bus0.req_last = 3'b111; bus0.spi_ready = 1'b1; bus0.spi_idle = 1'b1;
        gen_bytes = 0; sent_bytes = 0; cs_run = 0;
        run_check_en = 1'b0; seen_low = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = 3'b111;
        bus.spi_ready = 1'b1;
        #1;
        chk("rst_cs_n",      32'(bus.cs_n),      32'd1);
        chk("rst_grant",     32'(bus.grant),     32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_spi_valid", 32'(bus.spi_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // Fairness: everyone holds single-byte packets, link always ready
        hold_valid = 1'b1; ready_pct = 100; idle_pct = 100;
        run_check_en = 1'b1; seen_low = 1'b0; cs_run = 0;
        grant_log.delete();
        for (int r = 0; r < N; r++) begin
            add_packet(r, 1);
            add_packet(r, 1);
        end
        run_until_done("fair_done");
        chk("fair_cnt", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < grant_log.size() && k < 6; k++)
            chk("fair_order", 32'(grant_log[k]), 32'(fair_exp[k]));
        chk("fair_bytes", 32'(sent_bytes), 32'(gen_bytes));
        run_check_en = 1'b0;

        // Random traffic with valid drops, backpressure and slow transmitter drain
        hold_valid = 1'b0; ready_pct = 60; idle_pct = 40;
        for (int r = 0; r < N; r++)
            for (int p = 0; p < 4 + int'($urandom_range(3)); p++)
                add_packet(r, 1 + int'($urandom_range(3)));
        run_until_done("rand_done");
        chk("rand_bytes", 32'(sent_bytes), 32'(gen_bytes));

        // Reset after the first byte of a 4-byte packet
        hold_valid = 1'b1; ready_pct = 100; idle_pct = 100;
        sent_bytes = 0; gen_bytes = 0;
        add_packet(0, 4);
        for (int g = 0; g < 50 && sent_bytes < 1; g++) cycle();
        chk("mid_sent", 32'(sent_bytes), 32'd1);
        chk("mid_cs_n_before", 32'(bus.cs_n), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_cs_n",      32'(bus.cs_n),      32'd1);
        chk("mid_grant",     32'(bus.grant),     32'd0);
        chk("mid_spi_valid", 32'(bus.spi_valid), 32'd0);
        chk("mid_req_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_busy",      32'(bus.busy),      32'd0);
        for (int r = 0; r < N; r++) src_q[r].delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        grant_log.delete();
        add_packet(0, 1);
        add_packet(2, 1);
        run_until_done("post_rst_done");
        chk("post_rst_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("post_rst_first",  32'(grant_log[0]), 32'd0);
            chk("post_rst_second", 32'(grant_log[1]), 32'd2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
